// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant, bounded hold time
// and a mandatory idle cycle between owners.
module rr_arbiter_8 #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         gnt_q, gnt_d;
    logic [2:0]         gnt_idx_q, gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;

    logic               win_found;
    logic [2:0]         win_idx;
    logic [2:0]         cand;
    logic               hold_last;

    // Rotating priority search starting at ptr; a bit that is X never wins,
    // so at most one index is ever selected.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = '0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!win_found && (req[cand] == 1'b1)) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign hold_last = (HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_MAX - 1));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d       = 8'h00;
                gnt_valid_d = 1'b0;
                if (en && win_found) begin
                    state_d     = GRANT;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    gnt_d       = 8'b1 << win_idx;
                    cnt_d       = '0;
                end
            end
            GRANT: begin
                // Voluntary release wins over a coincident forced release.
                if (!req[gnt_idx_q] || hold_last) begin
                    state_d     = IDLE;
                    gnt_d       = 8'h00;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + 3'd1;
                    timeout_d   = req[gnt_idx_q] == 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: stimulus queues expected grant/release
// events, a monitor matches them against what the arbiter actually does.
module tb_rr_arbiter_8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [7:0] req = 8'hFF;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    rr_arbiter_8 #(.HOLD_MAX(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // kind 0 = grant appears (len = idle cycles before it, -1 = don't care)
    // kind 1 = grant drops   (len = cycles it was held, -1 = don't care)
    typedef struct {
        int         kind;
        logic [7:0] g;
        logic [2:0] idx;
        int         len;
        logic       to;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push_g(input logic [2:0] idx, input int gap);
        ev_t e;
        e.kind = 0; e.g = 8'b1 << idx; e.idx = idx; e.len = gap; e.to = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_r(input int hold, input logic to);
        ev_t e;
        e.kind = 1; e.g = 8'h00; e.idx = 3'd0; e.len = hold; e.to = to;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
    endtask

    // Present reqv, expect a grant to idx, keep it for hold cycles, then drop req.
    task automatic grant_then_drop(input logic [7:0] reqv, input logic [2:0] idx,
                                   input int hold, input int gap);
        push_g(idx, gap);
        push_r(hold, 1'b0);
        req = reqv;
        wait_cyc(hold);
        req = 8'h00;
        wait_cyc(1);
    endtask

    // Monitor
    initial begin
        ev_t e;
        bit  prev_valid = 1'b0;
        int  hold = 0;
        int  idle = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                if (gnt_valid === 1'b1 && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", {24'h0, gnt}, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind_grant", 32'(e.kind), 32'd0);
                        chk("gnt", {24'h0, gnt}, {24'h0, e.g});
                        chk("gnt_idx", {29'h0, gnt_idx}, {29'h0, e.idx});
                        if (e.len >= 0) chk("gap_cycles", 32'(idle), 32'(e.len));
                    end
                    hold = 1;
                end else if (gnt_valid === 1'b1) begin
                    hold++;
                end
                if (gnt_valid === 1'b0 && prev_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_release", 32'(hold), 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind_release", 32'(e.kind), 32'd1);
                        chk("gnt_after_release", {24'h0, gnt}, 32'h0);
                        chk("timeout", {31'h0, timeout}, {31'h0, e.to});
                        if (e.len >= 0) chk("hold_cycles", 32'(hold), 32'(e.len));
                    end
                    idle = 1;
                end else begin
                    if (gnt_valid === 1'b0) idle++;
                    chk("timeout_idle", {31'h0, timeout}, 32'h0);
                end
            end
            prev_valid = (gnt_valid === 1'b1);
        end
    end

    // Stimulus
    initial begin
        // 1. reset with everything requesting
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_gnt", {24'h0, gnt}, 32'h0);
            chk("rst_valid", {31'h0, gnt_valid}, 32'h0);
            chk("rst_timeout", {31'h0, timeout}, 32'h0);
            chk("rst_idx", {29'h0, gnt_idx}, 32'h0);
        end
        rst    = 1'b0;
        mon_on = 1'b1;
        grant_then_drop(8'h81, 3'd0, 3, -1);

        // 2. rotation 0,5,7,0 with one idle cycle between owners
        do_reset();
        chk("rst2_idx", {29'h0, gnt_idx}, 32'h0);
        req = 8'hA1;
        begin
            logic [2:0] order [4];
            logic [7:0] m;
            order[0] = 3'd0; order[1] = 3'd5; order[2] = 3'd7; order[3] = 3'd0;
            for (int k = 0; k < 4; k++) begin
                push_g(order[k], (k == 0) ? -1 : 1);
                push_r(3, 1'b0);
                wait_cyc(3);
                m   = 8'b1 << order[k];
                req = 8'hA1 & ~m;
                wait_cyc(1);
                req = (k == 3) ? 8'h00 : 8'hA1;
            end
        end

        // 3. wrap-around: after idx 5 releases, 0 beats 1; then drop in the last allowed cycle
        grant_then_drop(8'h20, 3'd5, 2, 1);
        grant_then_drop(8'h03, 3'd0, 4, 1);

        // 4. forced release of a sole requester, then handoff to the next requester
        push_g(3'd2, 1);  push_r(4, 1'b1);
        push_g(3'd2, 1);  push_r(4, 1'b1);
        req = 8'h04;
        wait_cyc(10);
        req = 8'h00;
        wait_cyc(1);
        do_reset();
        push_g(3'd2, -1); push_r(4, 1'b1);
        push_g(3'd3, 1);  push_r(2, 1'b0);
        req = 8'h0C;
        wait_cyc(7);
        req = 8'h00;
        wait_cyc(1);

        // 5. enable gates new grants only
        en  = 1'b0;
        req = 8'h10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("en_off_gnt", {24'h0, gnt}, 32'h0);
        end
        push_g(3'd4, -1);
        push_r(3, 1'b0);
        en = 1'b1;
        wait_cyc(1);
        en = 1'b0;
        wait_cyc(2);
        req = 8'h00;
        wait_cyc(1);
        en = 1'b1;

        // 6. reset while idx 6 owns the resource
        push_g(3'd6, -1);
        push_r(2, 1'b0);
        req = 8'h40;
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(1);
        chk("midrst_gnt", {24'h0, gnt}, 32'h0);
        chk("midrst_valid", {31'h0, gnt_valid}, 32'h0);
        chk("midrst_timeout", {31'h0, timeout}, 32'h0);
        push_g(3'd0, 1);
        push_r(2, 1'b0);
        rst = 1'b0;
        req = 8'hC1;
        wait_cyc(2);
        req = 8'h00;
        wait_cyc(3);

        chk("events_outstanding", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
